// File: rtl/clocked_ripple_counter_pkg.sv
// Shared discrete-logic definitions for the falling-edge strobe convention.
// Active-low slow clocks idle high, so edge registers reset to this level.
package clocked_ripple_counter_pkg;

   localparam logic EDGE_IDLE = 1'b1;

endpackage

// File: rtl/clocked_ripple_counter_fall_detect.sv
// Falling-edge strobe for a slow active-low clock sampled on CLK_DRV.
// FALL is combinational on the live input so it fires the first cycle the low level is seen.
module fall_detect
   import clocked_ripple_counter_pkg::*;
(
   input  logic CLK_DRV,
   input  logic RESET,
   input  logic IN_N,
   output logic FALL
);

   logic in_q;

   always_ff @(posedge CLK_DRV) begin
      if (RESET) in_q <= EDGE_IDLE;
      else       in_q <= IN_N;
   end

   assign FALL = in_q & ~IN_N;

endmodule

// File: rtl/clocked_ripple_counter.sv
// 7493-style ripple counter emulated synchronously on CLK_DRV, publishing each
// bit as a level plus a one-cycle 1->0 strobe for downstream falling-edge flops.
module clocked_ripple_counter
   import clocked_ripple_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter bit SPLIT = 1'b0
)
(
   input  logic             CLK_DRV,
   input  logic             RESET,
   input  logic             CLK_N,
   input  logic             CLKB_N,
   input  logic             R0_1,
   input  logic             R0_2,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_FALL
);

   localparam int CNT_W = WIDTH;
   localparam int UP_W  = WIDTH - 1;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [UP_W-1:0]  up_t;

   cnt_t cnt;
   cnt_t cnt_nxt;
   cnt_t carry_fall;
   up_t  up_nxt;
   logic fall_a;
   logic fall_b;
   logic clr;
   logic clr_q;
   logic clr_onset;
   logic up_fall;
   logic up_step;
   logic ones_below;

   fall_detect u_fall_a (
      .CLK_DRV (CLK_DRV),
      .RESET   (RESET),
      .IN_N    (CLK_N),
      .FALL    (fall_a)
   );

   fall_detect u_fall_b (
      .CLK_DRV (CLK_DRV),
      .RESET   (RESET),
      .IN_N    (CLKB_N),
      .FALL    (fall_b)
   );

   assign clr       = R0_1 & R0_2;
   assign clr_onset = clr & ~clr_q;

   // In cascade mode the whole ripple from bit 0 into the upper section collapses into one cycle.
   assign up_fall = SPLIT ? fall_b : fall_a;
   assign up_step = SPLIT ? fall_b : (fall_a & cnt[0]);
   assign up_nxt  = cnt[WIDTH-1:1] + up_t'(up_step);

   always_comb begin
      carry_fall    = '0;
      ones_below    = SPLIT ? 1'b1 : cnt[0];
      carry_fall[0] = fall_a & cnt[0];
      for (int i = 1; i < WIDTH; i++) begin
         ones_below    = ones_below & cnt[i];
         carry_fall[i] = up_fall & ones_below;
      end
   end

   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt[0]         = cnt[0] ^ fall_a;
         cnt_nxt[WIDTH-1:1] = up_nxt;
      end
   end

   always_ff @(posedge CLK_DRV) begin
      if (RESET) begin
         cnt   <= '0;
         clr_q <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         clr_q <= clr;
      end
   end

   assign Q = (RESET | clr) ? '0 : cnt;

   // Clear onset reports every set bit falling; a held clear stays silent.
   always_comb begin
      Q_FALL = '0;
      if (!RESET) begin
         if (clr) Q_FALL = clr_onset ? cnt : '0;
         else     Q_FALL = carry_fall;
      end
   end

endmodule

// File: tb/tb_clocked_ripple_counter.sv
// Scoreboard bench for clocked_ripple_counter: one cascade and one split instance
// checked against an arithmetic count model, plus directed boundary expectations.
module tb_clocked_ripple_counter;

   localparam int SEL_CQ   = 0;
   localparam int SEL_CQF  = 1;
   localparam int SEL_SQ   = 2;
   localparam int SEL_SQF  = 3;
   localparam int SEL_VIOL = 4;
   localparam int SEL_QF3  = 5;
   localparam int SEL_QF0  = 6;
   localparam int SEL_CLRA = 7;

   typedef struct {
      logic [3:0] q;
      logic [3:0] qf;
   } exp_t;

   typedef struct {
      string name;
      int    sel;
      int    val;
      int    cyc;
   } dchk_t;

   logic       CLK_DRV = 1'b0;
   logic       RESET   = 1'b1;
   logic       CLK_N   = 1'b1;
   logic       CLKB_N  = 1'b1;
   logic       R0_1    = 1'b0;
   logic       R0_2    = 1'b0;
   logic [3:0] q_c, qf_c, q_s, qf_s;

   always #5 CLK_DRV = ~CLK_DRV;

   clocked_ripple_counter #(.WIDTH(4), .SPLIT(1'b0)) dut_c (
      .CLK_DRV (CLK_DRV), .RESET (RESET), .CLK_N (CLK_N), .CLKB_N (CLKB_N),
      .R0_1 (R0_1), .R0_2 (R0_2), .Q (q_c), .Q_FALL (qf_c)
   );

   clocked_ripple_counter #(.WIDTH(4), .SPLIT(1'b1)) dut_s (
      .CLK_DRV (CLK_DRV), .RESET (RESET), .CLK_N (CLK_N), .CLKB_N (CLKB_N),
      .R0_1 (R0_1), .R0_2 (R0_2), .Q (q_s), .Q_FALL (qf_s)
   );

   exp_t  sb_c[$];
   exp_t  sb_s[$];
   dchk_t dq[$];
   int    cyc = 0;
   int    n_vec = 0;
   int    n_bad = 0;
   bit    done = 0;

   // Reference model: counts as integers; a strobe is any bit that goes 1->0.
   int c_val = 0, s_lo = 0, s_hi = 0;
   bit m_pa = 1, m_pb = 1, m_clrq = 0;

   task automatic model_step(input bit rst, input bit cn, input bit cbn, input bit clr);
      bit   fa, fb;
      int   oc, nc, os, ns;
      exp_t ec, es;
      fa = m_pa & ~cn;
      fb = m_pb & ~cbn;
      if (rst) begin
         ec = '{4'd0, 4'd0};
         es = '{4'd0, 4'd0};
         c_val = 0; s_lo = 0; s_hi = 0;
         m_pa = 1; m_pb = 1; m_clrq = 0;
      end else begin
         m_pa = cn;
         m_pb = cbn;
         if (clr) begin
            ec.q  = 4'd0;
            ec.qf = m_clrq ? 4'd0 : 4'(c_val);
            es.q  = 4'd0;
            es.qf = m_clrq ? 4'd0 : 4'(s_hi * 2 + s_lo);
            c_val = 0; s_lo = 0; s_hi = 0;
            m_clrq = 1;
         end else begin
            oc    = c_val;
            nc    = (c_val + int'(fa)) % 16;
            ec.q  = 4'(oc);
            ec.qf = 4'(oc & ~nc);
            c_val = nc;
            os    = s_hi * 2 + s_lo;
            s_lo  = (s_lo + int'(fa)) % 2;
            s_hi  = (s_hi + int'(fb)) % 8;
            ns    = s_hi * 2 + s_lo;
            es.q  = 4'(os);
            es.qf = 4'(os & ~ns);
            m_clrq = 0;
         end
      end
      sb_c.push_back(ec);
      sb_s.push_back(es);
   endtask

   task automatic drive(input bit rst, input bit cn, input bit cbn, input bit r1, input bit r2);
      @(posedge CLK_DRV);
      #1;
      RESET  = rst;
      CLK_N  = cn;
      CLKB_N = cbn;
      R0_1   = r1;
      R0_2   = r2;
      model_step(rst, cn, cbn, r1 & r2);
   endtask

   // Directed expectation for the cycle just driven.
   task automatic want(input string name, input int sel, input int val);
      dchk_t d;
      d.name = name; d.sel = sel; d.val = val; d.cyc = cyc;
      dq.push_back(d);
   endtask

   task automatic do_reset();
      repeat (3) drive(1, 1, 1, 0, 0);
      repeat (2) drive(0, 1, 1, 0, 0);
   endtask

   task automatic pulses_a(input int n);
      for (int k = 0; k < n; k++) begin
         repeat (2) drive(0, 0, 1, 0, 0);
         repeat (2) drive(0, 1, 1, 0, 0);
      end
   endtask

   // Monitor: the only process that compares.
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t  e;
      dchk_t d;
      int    low_run = 0, viol = 0, qf3_acc = 0, qf0_acc = 0;
      logic [31:0] act;
      forever begin
         @(negedge CLK_DRV);
         if (sb_c.size() > 0) begin
            e = sb_c.pop_front();
            chk("cascade Q", 32'(q_c), 32'(e.q));
            chk("cascade Q_FALL", 32'(qf_c), 32'(e.qf));
         end
         if (sb_s.size() > 0) begin
            e = sb_s.pop_front();
            chk("split Q", 32'(q_s), 32'(e.q));
            chk("split Q_FALL", 32'(qf_s), 32'(e.qf));
         end
         while (dq.size() > 0 && dq[0].cyc == cyc) begin
            d = dq.pop_front();
            if (d.sel == SEL_CLRA) begin
               qf3_acc = 0;
               qf0_acc = 0;
            end else begin
               case (d.sel)
                  SEL_CQ:   act = 32'(q_c);
                  SEL_CQF:  act = 32'(qf_c);
                  SEL_SQ:   act = 32'(q_s);
                  SEL_SQF:  act = 32'(qf_s);
                  SEL_VIOL: act = 32'(viol);
                  SEL_QF3:  act = 32'(qf3_acc);
                  default:  act = 32'(qf0_acc);
               endcase
               chk(d.name, act, 32'(d.val));
            end
         end
         if (CLK_N === 1'b0) begin
            low_run++;
         end else begin
            if (low_run > 0 && low_run < 2) begin
               viol++;
               $display("NOTE: CLK_N low for %0d cycle(s) ending at cycle %0d, below 2-cycle minimum", low_run, cyc);
            end
            low_run = 0;
         end
         qf3_acc += int'(qf_c[3] === 1'b1);
         qf0_acc += int'(qf_c[0] === 1'b1);
         cyc++;
         if (done && sb_c.size() == 0 && sb_s.size() == 0 && dq.size() == 0) begin
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      bit al, bl, rst, r1, r2;
      int ah, bh, clr_left;

      // 16 falls in cascade mode
      do_reset();
      want("acc clear", SEL_CLRA, 0);
      for (int k = 1; k <= 16; k++) begin
         drive(0, 0, 1, 0, 0);
         drive(0, 0, 1, 0, 0);
         want("cascade count step", SEL_CQ, k % 16);
         repeat (2) drive(0, 1, 1, 0, 0);
      end
      drive(0, 1, 1, 0, 0);
      want("Q_FALL[3] firings over 16 falls", SEL_QF3, 1);
      want("Q_FALL[0] firings over 16 falls", SEL_QF0, 8);

      // 0111 -> 1000 carry
      do_reset();
      pulses_a(7);
      drive(0, 0, 1, 0, 0);
      want("carry strobe at 0111", SEL_CQF, 4'b0111);
      drive(0, 0, 1, 0, 0);
      want("value after 0111 carry", SEL_CQ, 4'b1000);
      repeat (2) drive(0, 1, 1, 0, 0);

      // clear from 1010
      do_reset();
      pulses_a(10);
      drive(0, 1, 1, 1, 1);
      want("clear onset Q", SEL_CQ, 0);
      want("clear onset Q_FALL", SEL_CQF, 4'b1010);
      drive(0, 0, 1, 1, 1);
      want("held clear Q_FALL", SEL_CQF, 0);
      drive(0, 0, 1, 1, 1);
      want("held clear Q", SEL_CQ, 0);
      drive(0, 0, 1, 0, 0);
      want("release low Q_FALL", SEL_CQF, 0);
      drive(0, 0, 1, 0, 0);
      want("release low no count", SEL_CQ, 0);
      repeat (2) drive(0, 1, 1, 0, 0);
      repeat (2) drive(0, 0, 1, 0, 0);
      want("first fall after clear", SEL_CQ, 1);
      repeat (2) drive(0, 1, 1, 0, 0);

      // split mode: simultaneous falls then two more CLKB_N falls
      do_reset();
      drive(0, 0, 0, 0, 0);
      want("split joint fall Q_FALL", SEL_SQF, 0);
      drive(0, 0, 0, 0, 0);
      want("split joint fall Q", SEL_SQ, 4'b0011);
      repeat (2) drive(0, 1, 1, 0, 0);
      for (int k = 0; k < 2; k++) begin
         repeat (2) drive(0, 1, 0, 0, 0);
         repeat (2) drive(0, 1, 1, 0, 0);
      end
      want("split final Q", SEL_SQ, 4'b0111);

      // reset at 1111 coinciding with a fall
      do_reset();
      pulses_a(15);
      drive(1, 0, 1, 0, 0);
      want("reset with fall Q", SEL_CQ, 0);
      want("reset with fall Q_FALL", SEL_CQF, 0);
      drive(1, 0, 1, 0, 0);
      want("held reset Q_FALL", SEL_CQF, 0);
      drive(0, 1, 1, 0, 0);
      want("after reset Q_FALL", SEL_CQF, 0);
      drive(0, 1, 1, 0, 0);
      repeat (2) drive(0, 0, 1, 0, 0);
      want("first fall after reset", SEL_CQ, 1);
      repeat (2) drive(0, 1, 1, 0, 0);

      // 1-cycle low between two legal pulses
      do_reset();
      pulses_a(1);
      want("after first legal pulse", SEL_CQ, 1);
      drive(0, 0, 1, 0, 0);
      repeat (2) drive(0, 1, 1, 0, 0);
      pulses_a(1);
      drive(0, 1, 1, 0, 0);
      want("min-width violations flagged", SEL_VIOL, 1);
      want("count after short pulse", SEL_CQ, 3);

      // randomized traffic, both instances against the model
      al = 1; bl = 1; ah = 2; bh = 3; clr_left = 0;
      for (int n = 0; n < 1200; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (clr_left > 0) begin
            r1 = 1; r2 = 1; clr_left = clr_left - 1;
         end else if ($urandom_range(0, 29) == 0) begin
            r1 = 1; r2 = 1; clr_left = $urandom_range(0, 3);
         end else begin
            r1 = ($urandom_range(0, 3) == 0);
            r2 = !r1 && ($urandom_range(0, 3) == 0);
         end
         drive(rst, al, bl, r1, r2);
         ah = ah - 1;
         if (ah == 0) begin al = ~al; ah = $urandom_range(2, 5); end
         bh = bh - 1;
         if (bh == 0) begin bl = ~bl; bh = $urandom_range(2, 5); end
      end
      drive(0, 1, 1, 0, 0);

      done = 1;
      repeat (50) @(posedge CLK_DRV);
      $display("FAIL drain: scoreboard not empty after 50 cycles (c=%0d s=%0d d=%0d)",
               sb_c.size(), sb_s.size(), dq.size());
      $fatal(1, "drain timeout");
   end

endmodule
